// File: rtl/vector_result_collector_if.sv
// ============================================================================
// vector_result_collector_if
// Issue/result/output bus between the dot-product feeder and the collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vector_result_collector_if #(
  parameter int DW  = 32,
  parameter int NUM = 16
);
  logic              issue_valid;
  logic              issue_ready;
  logic [DW-1:0]     result_data;
  logic              flush;
  logic [DW*NUM-1:0] out_data;
  logic [4:0]        out_lanes;
  logic              out_valid;
  logic              out_ready;
  logic              err_drop;

  modport master (
    output issue_valid, result_data, flush, out_ready,
    input  issue_ready, out_data, out_lanes, out_valid, err_drop
  );

  modport slave (
    input  issue_valid, result_data, flush, out_ready,
    output issue_ready, out_data, out_lanes, out_valid, err_drop
  );
endinterface

`default_nettype wire

// File: rtl/vector_result_collector.sv
// ============================================================================
// vector_result_collector
// Tracks dot-product issues through a fixed-latency pipe, packs the scalar
// results NUM per word and buffers the packed words in a small output FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_result_collector #(
  parameter int DW         = 32,
  parameter int NUM        = 16,
  parameter int LAT        = 52,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  vector_result_collector_if.slave    bus
);

  localparam int          CW  = $clog2(NUM + 1);
  localparam int          IW  = $clog2(LAT + 1);
  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          FW  = $clog2(FIFO_DEPTH + 1);
  localparam int          WW  = DW * NUM;
  localparam logic [31:0] CAP = 32'(NUM * FIFO_DEPTH);

  logic [LAT-1:0] vld_q,   vld_d;
  logic [IW-1:0]  infl_q,  infl_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [WW-1:0]  pack_q,  pack_d;
  logic           fpend_q, fpend_d;
  logic [IW-1:0]  fwait_q, fwait_d;
  logic           err_q,   err_d;
  logic [PW-1:0]  wr_q,    wr_d;
  logic [PW-1:0]  rd_q,    rd_d;
  logic [FW-1:0]  fcnt_q,  fcnt_d;
  logic [WW-1:0]  mem_data_q  [FIFO_DEPTH];
  logic [4:0]     mem_lanes_q [FIFO_DEPTH];

  logic [31:0]    w_occ;
  logic           w_rdy, w_acc, w_cap, w_go, w_push, w_pop;
  logic [WW-1:0]  w_ins, w_push_data;
  logic [4:0]     w_push_lanes;

  // Every in-flight issue, packed result and buffered word reserves FIFO space.
  assign w_occ = 32'(infl_q) + 32'(cnt_q) + 32'(fcnt_q) * 32'(NUM);
  assign w_rdy = (w_occ < CAP);
  assign w_acc = bus.issue_valid & w_rdy;
  assign w_cap = vld_q[LAT-1];
  assign w_go  = fpend_q & (fwait_q == '0);
  assign w_pop = (fcnt_q != '0) & bus.out_ready;

  assign bus.issue_ready = w_rdy;
  assign bus.err_drop    = err_q;
  assign bus.out_valid   = (fcnt_q != '0);
  assign bus.out_data    = (fcnt_q != '0) ? mem_data_q[rd_q]  : '0;
  assign bus.out_lanes   = (fcnt_q != '0) ? mem_lanes_q[rd_q] : '0;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = w_acc;
    infl_d   = infl_q + IW'(w_acc) - IW'(w_cap);
    err_d    = err_q | (bus.issue_valid & ~w_rdy);

    w_ins = pack_q;
    for (int k = 0; k < NUM; k++) begin
      if (w_cap && cnt_q == CW'(k)) w_ins[k*DW +: DW] = bus.result_data;
    end

    pack_d       = pack_q;
    cnt_d        = cnt_q;
    w_push       = 1'b0;
    w_push_data  = pack_q;
    w_push_lanes = '0;
    if (w_cap && cnt_q == CW'(NUM - 1)) begin
      w_push       = 1'b1;
      w_push_data  = w_ins;
      w_push_lanes = 5'(NUM);
      pack_d       = '0;
      cnt_d        = '0;
    end else if (w_go && cnt_q != '0) begin
      // A capture in the flush cycle starts the next word in lane 0.
      w_push       = 1'b1;
      w_push_lanes = 5'(cnt_q);
      pack_d       = '0;
      cnt_d        = '0;
      if (w_cap) begin
        pack_d[DW-1:0] = bus.result_data;
        cnt_d          = CW'(1);
      end
    end else if (w_cap) begin
      pack_d = w_ins;
      cnt_d  = cnt_q + CW'(1);
    end

    fpend_d = fpend_q;
    fwait_d = fwait_q;
    if (fpend_q && fwait_q != '0 && w_cap) fwait_d = fwait_q - IW'(1);
    if (w_go) fpend_d = 1'b0;
    // Only results already in flight at the flush are waited for.
    if (bus.flush) begin
      fpend_d = 1'b1;
      fwait_d = infl_q - IW'(w_cap);
    end

    wr_d   = w_push ? wr_q + PW'(1) : wr_q;
    rd_d   = w_pop  ? rd_q + PW'(1) : rd_q;
    fcnt_d = fcnt_q + FW'(w_push) - FW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      infl_q  <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      fpend_q <= 1'b0;
      fwait_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      fpend_q <= fpend_d;
      fwait_q <= fwait_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_data_q[wr_q]  <= w_push_data;
      mem_lanes_q[wr_q] <= w_push_lanes;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && fcnt_q == FW'(FIFO_DEPTH)));

endmodule

`default_nettype wire
